// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO slice.
package fifo_pkg;

    localparam int DATA_LEN_DEF = 32;
    localparam int ADDR_LEN_DEF = 4;
    localparam int DEPTH        = 32'd1 << ADDR_LEN_DEF;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_LEN-1:0] rd_addr,
    output logic [DATA_LEN-1:0] rd_data
);

    localparam int MEM_DEPTH = 32'd1 << ADDR_LEN;

    logic [DATA_LEN-1:0] mem_r [MEM_DEPTH];
    logic [DATA_LEN-1:0] rd_data_r;

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: holds the last word read until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_LEN{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo_wrapper.sv
// Single-clock FIFO: wrap-bit pointers with registered full/empty flags and 1-cycle read latency.
module sync_fifo_wrapper
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [DATA_LEN-1:0] wdata_i,
    output logic [DATA_LEN-1:0] rdata_o,
    output logic                rempty_o,
    output logic                wfull_o
);

    localparam int                 PTR_LEN = ADDR_LEN + 1;
    localparam logic [PTR_LEN-1:0] PTR_ONE = {{ADDR_LEN{1'b0}}, 1'b1};

    logic [PTR_LEN-1:0] wptr_r;
    logic [PTR_LEN-1:0] rptr_r;
    logic [PTR_LEN-1:0] wptr_next_s;
    logic [PTR_LEN-1:0] rptr_next_s;
    logic               wr_accept_s;
    logic               rd_accept_s;
    logic               empty_next_s;
    logic               full_next_s;
    logic               rempty_r;
    logic               wfull_r;

    // Request gating against the registered flags and next-pointer/flag computation.
    always_comb begin
        wr_accept_s  = 1'b0;
        rd_accept_s  = 1'b0;
        wptr_next_s  = wptr_r;
        rptr_next_s  = rptr_r;
        empty_next_s = 1'b1;
        full_next_s  = 1'b0;

        wr_accept_s = write_en & ~wfull_r;
        rd_accept_s = read_en & ~rempty_r;

        if (wr_accept_s) begin
            wptr_next_s = wptr_r + PTR_ONE;
        end else begin
            wptr_next_s = wptr_r;
        end

        if (rd_accept_s) begin
            rptr_next_s = rptr_r + PTR_ONE;
        end else begin
            rptr_next_s = rptr_r;
        end

        // Same address with opposite wrap bits means a full lap ahead.
        empty_next_s = (wptr_next_s == rptr_next_s);
        full_next_s  = (wptr_next_s[ADDR_LEN] != rptr_next_s[ADDR_LEN]) &&
                       (wptr_next_s[ADDR_LEN-1:0] == rptr_next_s[ADDR_LEN-1:0]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r   <= {PTR_LEN{1'b0}};
            rptr_r   <= {PTR_LEN{1'b0}};
            rempty_r <= 1'b1;
            wfull_r  <= 1'b0;
        end else begin
            wptr_r   <= wptr_next_s;
            rptr_r   <= rptr_next_s;
            rempty_r <= empty_next_s;
            wfull_r  <= full_next_s;
        end
    end

    fifo_mem #(
        .DATA_LEN (DATA_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept_s),
        .wr_addr (wptr_r[ADDR_LEN-1:0]),
        .wr_data (wdata_i),
        .rd_en   (rd_accept_s),
        .rd_addr (rptr_r[ADDR_LEN-1:0]),
        .rd_data (rdata_o)
    );

    assign rempty_o = rempty_r;
    assign wfull_o  = wfull_r;

endmodule

// File: tb/tb_sync_fifo_wrapper.sv
// Scoreboard bench for sync_fifo_wrapper: stimulus pushes expected state, a negedge monitor compares.
module tb_sync_fifo_wrapper;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          write_en;
    logic          read_en;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          rempty_o;
    logic          wfull_o;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          empty;
        logic          full;
        int            phase;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_rdata;
    int            phase;
    int            checks;
    int            errors;

    sync_fifo_wrapper #(.DATA_LEN(DW), .ADDR_LEN(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .write_en (write_en),
        .read_en  (read_en),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rempty_o (rempty_o),
        .wfull_o  (wfull_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare DUT outputs with the expected entry queued after the preceding edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 3;
            if (rdata_o !== mon_e.rdata) begin
                errors = errors + 1;
                $display("FAIL rdata phase %0d: got %h expected %h", mon_e.phase, rdata_o, mon_e.rdata);
            end
            if (rempty_o !== mon_e.empty) begin
                errors = errors + 1;
                $display("FAIL rempty phase %0d: got %b expected %b", mon_e.phase, rempty_o, mon_e.empty);
            end
            if (wfull_o !== mon_e.full) begin
                errors = errors + 1;
                $display("FAIL wfull phase %0d: got %b expected %b", mon_e.phase, wfull_o, mon_e.full);
            end
        end
    end

    task automatic push_expect();
        exp_t e;
        e.rdata = m_rdata;
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == DEPTH);
        e.phase = phase;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus, called at a negedge; the reference model decides acceptance.
    task automatic do_cycle(input logic we, input logic re, input logic [DW-1:0] wd);
        logic w_acc;
        logic r_acc;
        write_en = we;
        read_en  = re;
        wdata_i  = wd;
        w_acc = we && (model_q.size() != DEPTH);
        r_acc = re && (model_q.size() != 0);
        if (r_acc) m_rdata = model_q.pop_front();
        if (w_acc) model_q.push_back(wd);
        @(posedge clk);
        push_expect();
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        phase    = 0;
        rst_n    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        wdata_i  = '0;
        m_rdata  = '0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;

        phase = 1;
        do_cycle(1'b0, 1'b0, 32'h0);

        phase = 2;
        for (int i = 1; i <= 16; i++) do_cycle(1'b1, 1'b0, DW'(i));
        do_cycle(1'b1, 1'b0, 32'h0000_DEAD);

        phase = 3;
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0);

        phase = 4;
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 32'hA000_0000 + DW'(i));
        do_cycle(1'b1, 1'b1, 32'h0000_BEEF);
        do_cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 1'b1, 32'h0);

        phase = 5;
        do_cycle(1'b1, 1'b1, 32'h0000_CAFE);
        do_cycle(1'b0, 1'b1, 32'h0);

        phase = 6;
        for (int i = 0; i < 1000; i++) do_cycle(1'b1, 1'b1, DW'($urandom));
        for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b1, 32'h0);

        phase = 7;
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
        end

        phase = 8;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'h0000_1234 + DW'(i));
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_q.delete();
        m_rdata = '0;
        push_expect();
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, 1'b1, 32'h0);
        do_cycle(1'b1, 1'b0, 32'h0000_0055);
        do_cycle(1'b0, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
